// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2^IDX_W two-bit saturating counters indexed by PC[IDX_W+1:2].
// Define BP_STATS_EN to add the Stat_Branches / Stat_Mispredicts counters and ports.
module branch_predictor #(
  parameter int unsigned IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  output logic        IF_PredTaken,
  input  logic        ID_BrValid,
  input  logic [31:0] ID_PC,
  input  logic        ID_Taken,
  input  logic        ID_PredTaken,
`ifdef BP_STATS_EN
  output logic [31:0] Stat_Branches,
  output logic [31:0] Stat_Mispredicts,
`endif
  output logic        Mispredict
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]       r_table [DEPTH];
  logic             r_mispredict;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_id_idx;
  logic             w_mispredict;
  logic             w_unused;

  assign w_if_idx     = IF_PC[IDX_W+1:2];
  assign w_id_idx     = ID_PC[IDX_W+1:2];
  assign w_mispredict = ID_BrValid & (ID_Taken ^ ID_PredTaken);
  // PC bits outside the index field take no part in prediction (no tags).
  assign w_unused     = ^{IF_PC[31:IDX_W+2], IF_PC[1:0], ID_PC[31:IDX_W+2], ID_PC[1:0]};

  // Read is straight from the table, so a same-cycle update is not bypassed.
  assign IF_PredTaken = r_table[w_if_idx][1];
  assign Mispredict   = r_mispredict;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_table <= '{default: 2'b01};
    end else if (ID_BrValid) begin
      if (ID_Taken && (r_table[w_id_idx] != 2'b11))
        r_table[w_id_idx] <= r_table[w_id_idx] + 2'b01;
      else if (!ID_Taken && (r_table[w_id_idx] != 2'b00))
        r_table[w_id_idx] <= r_table[w_id_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_mispredict <= 1'b0;
    else        r_mispredict <= w_mispredict;
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (ID_BrValid)   r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign Stat_Branches    = r_stat_branches;
  assign Stat_Mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (IDX_W=4); stats checks only when BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC;
  logic        IF_PredTaken;
  logic        ID_BrValid;
  logic [31:0] ID_PC;
  logic        ID_Taken;
  logic        ID_PredTaken;
  logic        Mispredict;
`ifdef BP_STATS_EN
  logic [31:0] Stat_Branches;
  logic [31:0] Stat_Mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(.IDX_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .IF_PC            (IF_PC),
    .IF_PredTaken     (IF_PredTaken),
    .ID_BrValid       (ID_BrValid),
    .ID_PC            (ID_PC),
    .ID_Taken         (ID_Taken),
    .ID_PredTaken     (ID_PredTaken),
`ifdef BP_STATS_EN
    .Stat_Branches    (Stat_Branches),
    .Stat_Mispredicts (Stat_Mispredicts),
`endif
    .Mispredict       (Mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One resolved branch, applied across a single edge, then BrValid dropped.
  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    ID_BrValid   = 1'b1;
    ID_PC        = pc;
    ID_Taken     = taken;
    ID_PredTaken = pred;
    tick();
    ID_BrValid   = 1'b0;
  endtask

  task automatic predict(input string tag, input logic [31:0] pc, input logic exp);
    IF_PC = pc;
    #1;
    check(tag, {31'd0, IF_PredTaken}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b0; IF_PC = 32'h3000; ID_BrValid = 1'b0;
    ID_PC = '0; ID_Taken = 1'b0; ID_PredTaken = 1'b0;
    #2;
    check("reset_mispredict", {31'd0, Mispredict}, 32'd0);
    predict("reset_pred_3000", 32'h3000, 1'b0);
    predict("reset_pred_303c", 32'h303C, 1'b0);
    #7 reset = 1'b1;

    // Weak-NT entry, taken branch predicted NT: mispredict and entry -> 10.
    IF_PC = 32'h3000;
    tick();
    check("basic_pre_pred", {31'd0, IF_PredTaken}, 32'd0);
    update(32'h3000, 1'b1, 1'b0);
    check("basic_mispredict", {31'd0, Mispredict}, 32'd1);
    check("basic_post_pred", {31'd0, IF_PredTaken}, 32'd1);
    tick();
    check("mispredict_pulse_end", {31'd0, Mispredict}, 32'd0);

    // Correct prediction and invalid-branch cycles never flag a mispredict.
    update(32'h3010, 1'b1, 1'b1);
    check("correct_no_mispredict", {31'd0, Mispredict}, 32'd0);
    ID_Taken = 1'b1; ID_PredTaken = 1'b0; ID_PC = 32'h3014;
    tick();
    check("invalid_no_mispredict", {31'd0, Mispredict}, 32'd0);
    predict("invalid_no_update", 32'h3014, 1'b0);

    // Saturation at 11 then 00 on 0x3004.
    for (int i = 0; i < 5; i++) update(32'h3004, 1'b1, 1'b1);
    predict("sat_hi_pred", 32'h3004, 1'b1);
    update(32'h3004, 1'b0, 1'b1);
    predict("sat_hi_dec_10", 32'h3004, 1'b1);
    update(32'h3004, 1'b0, 1'b1);
    predict("sat_hi_dec_01", 32'h3004, 1'b0);
    for (int i = 0; i < 3; i++) update(32'h3004, 1'b0, 1'b0);
    update(32'h3004, 1'b1, 1'b0);
    predict("sat_lo_inc_01", 32'h3004, 1'b0);
    update(32'h3004, 1'b1, 1'b0);
    predict("sat_lo_inc_10", 32'h3004, 1'b1);

    // Same-cycle read/update of one entry sees the old value.
    IF_PC = 32'h3008; ID_PC = 32'h3008; ID_BrValid = 1'b1;
    ID_Taken = 1'b1; ID_PredTaken = 1'b0;
    #1;
    check("nobypass_same_cycle", {31'd0, IF_PredTaken}, 32'd0);
    tick();
    ID_BrValid = 1'b0;
    check("nobypass_next_cycle", {31'd0, IF_PredTaken}, 32'd1);

    // Aliasing: 0x3000 and 0x3040 share entry 0 (currently 10); low PC bits ignored.
    predict("alias_3040_pred", 32'h3040, 1'b1);
    update(32'h3040, 1'b0, 1'b1);
    update(32'h3040, 1'b0, 1'b0);
    predict("alias_3000_after", 32'h3000, 1'b0);
    predict("pc_low_bits_ignored", 32'h3003, 1'b0);
    predict("neighbour_untouched", 32'h3008, 1'b1);

    // Async reset between edges with entry 11 and Mispredict high.
    update(32'h3000, 1'b1, 1'b1);
    update(32'h3000, 1'b1, 1'b1);
    update(32'h3000, 1'b1, 1'b0);
    IF_PC = 32'h3000;
    check("pre_reset_mispredict", {31'd0, Mispredict}, 32'd1);
    check("pre_reset_pred", {31'd0, IF_PredTaken}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_pred", {31'd0, IF_PredTaken}, 32'd0);
    check("async_reset_mispredict", {31'd0, Mispredict}, 32'd0);

    // Update presented while reset is held is discarded.
    ID_BrValid = 1'b1; ID_PC = 32'h3004; ID_Taken = 1'b1; ID_PredTaken = 1'b0;
    tick();
    ID_BrValid = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_discards_mispredict", {31'd0, Mispredict}, 32'd0);
    predict("reset_discards_update", 32'h3004, 1'b0);
    predict("reset_clears_3008", 32'h3008, 1'b0);
    update(32'h3004, 1'b1, 1'b0);
    predict("first_edge_after_reset", 32'h3004, 1'b1);
    check("first_edge_mispredict", {31'd0, Mispredict}, 32'd1);

`ifdef BP_STATS_EN
    reset = 1'b0;
    #2;
    check("stats_reset_br", Stat_Branches, 32'd0);
    check("stats_reset_mp", Stat_Mispredicts, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) update(32'h3000 + 32'(i * 4), 1'b1, (i < 3) ? 1'b0 : 1'b1);
    check("stats_branches", Stat_Branches, 32'd10);
    check("stats_mispredicts", Stat_Mispredicts, 32'd3);
    ID_Taken = 1'b1; ID_PredTaken = 1'b0;
    tick(); tick();
    check("stats_idle_br", Stat_Branches, 32'd10);
    check("stats_idle_mp", Stat_Mispredicts, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4: table index width; the table SHALL have 2^IDX_W entries.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 IF_PC  input  32  fetch-stage PC to be predicted.
REQ-005 IF_PredTaken  output  1  combinational prediction for IF_PC (1 = taken).
REQ-006 ID_BrValid  input  1  the ID-stage instruction is a resolved conditional branch this cycle.
REQ-007 ID_PC  input  32  PC of the resolving branch.
REQ-008 ID_Taken  input  1  actual outcome, driven from the branch comparator (Equal/Bgez-derived).
REQ-009 ID_PredTaken  input  1  prediction originally made for this branch, piped from IF.
REQ-010 Mispredict  output  1  registered one-cycle pulse when the outcome differed from the prediction.
REQ-011 Stat_Branches  output  32  resolved-branch count (only with BP_STATS_EN).
REQ-012 Stat_Mispredicts  output  32  mispredict count (only with BP_STATS_EN).

Function
REQ-013 The table SHALL hold one 2-bit saturating counter per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-014 The entry index SHALL be PC[IDX_W+1:2]; PC[1:0] SHALL be ignored.
REQ-015 IF_PredTaken SHALL equal bit 1 of the entry indexed by IF_PC, with zero-cycle latency.
REQ-016 When ID_BrValid=1, the entry indexed by ID_PC SHALL increment on ID_Taken=1 and decrement on ID_Taken=0 at the next edge.
REQ-017 Increments SHALL saturate at 11, and decrements SHALL saturate at 00; no wrap-around.
REQ-018 When ID_BrValid=0, no entry SHALL change.
REQ-019 Mispredict SHALL be 1 in the cycle after an edge where ID_BrValid=1 and ID_Taken!=ID_PredTaken, and 0 otherwise.
REQ-020 If IF_PC and ID_PC index the same entry in the same cycle, IF_PredTaken SHALL reflect the pre-update value (no bypass).
REQ-021 ID_Taken and ID_PredTaken SHALL be ignored when ID_BrValid=0.
REQ-022 Aliased PCs (same index) SHALL share one counter; no tag check.

Reset
REQ-023 Asserting reset SHALL immediately set every table entry to 01 (weak-NT), independent of clk.
REQ-024 Asserting reset SHALL immediately set Mispredict to 0 and Stat_Branches/Stat_Mispredicts to 0, independent of clk.
REQ-025 Reset asserted mid-update SHALL discard that update.
REQ-026 The first edge after deassertion SHALL operate normally.

Configuration
REQ-027 Macro BP_STATS_EN defined: the two 32-bit counters SHALL exist.
REQ-028 Under BP_STATS_EN: Stat_Branches SHALL increment on each ID_BrValid=1 edge, and Stat_Mispredicts SHALL increment on each mispredicting edge.
REQ-029 Under BP_STATS_EN: both counters SHALL wrap modulo 2^32.
REQ-030 Macro BP_STATS_EN undefined: the Stat_* ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then IF_PC=0x00003000 -> IF_PredTaken=0; ID_BrValid=1, ID_PC=0x00003000, ID_Taken=1, ID_PredTaken=0 -> next cycle Mispredict=1, IF_PredTaken=1 (entry 10).
REQ-032 Four taken updates to 0x00003004 from reset -> entry 11; a fifth taken update -> entry stays 11; one not-taken update -> IF_PredTaken still 1 (entry 10).
REQ-033 Same cycle IF_PC=ID_PC=0x00003008, entry 01, ID_Taken=1 -> IF_PredTaken=0 that cycle, and 1 the next cycle.
REQ-034 PCs 0x00003000 and 0x00003040 (IDX_W=4) -> an update via one changes the prediction for the other (aliasing).
REQ-035 Assert reset between edges with entry at 11 -> IF_PredTaken drops to 0 and Mispredict to 0 without a clock edge.
REQ-036 With BP_STATS_EN: 10 branches, 3 mispredicted -> Stat_Branches=10, Stat_Mispredicts=3; ID_BrValid=0 cycles leave both unchanged.
